fpu_fflags_accumulator: RTL and testbench

- Successor to the single-lane combinational FPU exception flag generator.
- Generates IEEE 754 {NV,DZ,OF,UF,NX} per SIMD lane across NUM_LANES lanes. Adds DIV/SQRT and a full FMA Inf−Inf check.
- ORs the lane flags and holds them in an in-order pending queue until the instruction commits; flushed entries never reach fflags.
- Owns the sticky fflags CSR field; sits between the FPU writeback stage and the CSR file.

---
 rtl/fpu_pkg.sv | 39 +++
 rtl/fpu_lane_flag_gen.sv | 56 +++++
 rtl/fpu_fflags_accumulator.sv | 118 +++++++++++
 tb/tb_fpu_fflags_accumulator.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU exception-flag accumulator: operation codes,
// flag/class bit positions and operand class layout.
package fpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_FMA  = 3'b011,
    OP_FMS  = 3'b100,
    OP_DIV  = 3'b101,
    OP_SQRT = 3'b110
  } op_e;

  localparam int FLAG_W = 5;
  localparam int CLS_W  = 5;
  localparam int RES_W  = 4;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int RES_INV = 3;
  localparam int RES_OF  = 2;
  localparam int RES_UF  = 1;
  localparam int RES_NX  = 0;

  // Operand classification as delivered per lane: {sign,snan,nan,inf,zero}.
  typedef struct packed {
    logic sign;
    logic snan;
    logic nan;
    logic inf;
    logic zero;
  } cls_t;

endpackage

// File: rtl/fpu_lane_flag_gen.sv
// Combinational IEEE 754 exception flags {NV,DZ,OF,UF,NX} for one SIMD lane.
module fpu_lane_flag_gen
  import fpu_pkg::*;
(
  input  logic [2:0]        op_type,
  input  cls_t              x_cls,
  input  cls_t              y_cls,
  input  cls_t              z_cls,
  input  logic [RES_W-1:0]  res_cls,
  output logic [FLAG_W-1:0] flags
);

  op_e  op;
  logic zero_times_inf;
  logic prod_inf;
  logic prod_sign;
  logic nv;
  logic dz;

  assign op             = op_e'(op_type);
  assign zero_times_inf = (x_cls.zero & y_cls.inf) | (x_cls.inf & y_cls.zero);
  assign prod_inf       = (x_cls.inf | y_cls.inf) & ~x_cls.zero & ~y_cls.zero
                          & ~x_cls.nan & ~y_cls.nan;
  assign prod_sign      = x_cls.sign ^ y_cls.sign;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    nv = x_cls.snan | y_cls.snan | z_cls.snan | res_cls[RES_INV];
    case (op)
      OP_ADD:  nv = nv | (x_cls.inf & y_cls.inf & (x_cls.sign ^ y_cls.sign));
      OP_SUB:  nv = nv | (x_cls.inf & y_cls.inf & ~(x_cls.sign ^ y_cls.sign));
      OP_MUL:  nv = nv | zero_times_inf;
      OP_FMA:  nv = nv | zero_times_inf | (prod_inf & z_cls.inf & (prod_sign ^ z_cls.sign));
      OP_FMS:  nv = nv | zero_times_inf | (prod_inf & z_cls.inf & ~(prod_sign ^ z_cls.sign));
      OP_DIV:  nv = nv | (x_cls.zero & y_cls.zero) | (x_cls.inf & y_cls.inf);
      OP_SQRT: nv = nv | (x_cls.sign & ~x_cls.zero & ~x_cls.nan);
      default: nv = nv;
    endcase
  end

  assign dz = (op == OP_DIV) & y_cls.zero & ~x_cls.nan & ~x_cls.inf & ~x_cls.zero;

  // An invalid or divide-by-zero result has no meaningful rounding outcome.
  always_comb begin
    flags          = '0;
    flags[FLAG_NV] = nv;
    flags[FLAG_DZ] = dz;
    if (!(nv | dz)) begin
      flags[FLAG_OF] = res_cls[RES_OF];
      flags[FLAG_UF] = res_cls[RES_UF];
      flags[FLAG_NX] = res_cls[RES_NX] | res_cls[RES_OF] | res_cls[RES_UF];
    end
  end

endmodule

// File: rtl/fpu_fflags_accumulator.sv
// Per-lane exception flags merged into an in-order pending queue; committed
// entries are ORed into the sticky fflags CSR field, flushed ones are dropped.
module fpu_fflags_accumulator
  import fpu_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [2:0]                 op_type,
  input  logic [NUM_LANES-1:0]       lane_en,
  input  logic [CLS_W*NUM_LANES-1:0] x_cls,
  input  logic [CLS_W*NUM_LANES-1:0] y_cls,
  input  logic [CLS_W*NUM_LANES-1:0] z_cls,
  input  logic [RES_W*NUM_LANES-1:0] res_cls,
  input  logic                       commit,
  input  logic                       flush,
  input  logic                       csr_we,
  input  logic                       csr_set,
  input  logic                       csr_clr,
  input  logic [FLAG_W-1:0]          csr_wdata,
  output logic [FLAG_W-1:0]          fflags,
  output logic [$clog2(DEPTH):0]     pending_cnt,
  output logic                       commit_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FLAG_W-1:0] lane_flags [NUM_LANES];
  logic [FLAG_W-1:0] enq_entry;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    fpu_lane_flag_gen u_lane (
      .op_type (op_type),
      .x_cls   (x_cls[CLS_W*i +: CLS_W]),
      .y_cls   (y_cls[CLS_W*i +: CLS_W]),
      .z_cls   (z_cls[CLS_W*i +: CLS_W]),
      .res_cls (res_cls[RES_W*i +: RES_W]),
      .flags   (lane_flags[i])
    );
  end

  always_comb begin
    enq_entry = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      enq_entry = enq_entry | (lane_flags[i] & {FLAG_W{lane_en[i]}});
    end
  end

  logic [FLAG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [FLAG_W-1:0] fflags_q, fflags_d;
  logic              err_q, err_d;
  logic              enq_fire, pop, mem_we;
  logic [FLAG_W-1:0] committed, csr_base;

  assign enq_ready = count_q < CNT_W'(DEPTH);
  assign enq_fire  = enq_valid & enq_ready;
  assign pop       = commit & (count_q != '0);
  assign mem_we    = enq_fire & ~flush;
  assign committed = pop ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(enq_fire);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(enq_fire) - CNT_W'(pop);
    // Flush drops everything after the head pop, including a same-cycle enqueue.
    if (flush) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end
  end

  always_comb begin
    if (csr_we)       csr_base = csr_wdata;
    else if (csr_set) csr_base = fflags_q | csr_wdata;
    else if (csr_clr) csr_base = fflags_q & ~csr_wdata;
    else              csr_base = fflags_q;
    fflags_d = csr_base | committed;
    err_d    = err_q | (commit & (count_q == '0));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fflags_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the entry storage is not reset; slots are only read when count_q
  // says they were written, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= enq_entry;
  end

  assign fflags      = fflags_q;
  assign pending_cnt = count_q;
  assign commit_err  = err_q;

endmodule

// File: tb/tb_fpu_fflags_accumulator.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a queue-based reference model of the flag accumulator.
module tb_fpu_fflags_accumulator;
  import fpu_pkg::*;

  localparam int NL    = 2;
  localparam int DEPTH = 4;

  localparam logic [4:0] C_PINF  = 5'b00010;
  localparam logic [4:0] C_NINF  = 5'b10010;
  localparam logic [4:0] C_PZERO = 5'b00001;
  localparam logic [4:0] C_FIN   = 5'b00000;  // positive finite nonzero
  localparam logic [4:0] C_SNAN  = 5'b01100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enq_valid;
  logic             enq_ready;
  logic [2:0]       op_type;
  logic [NL-1:0]    lane_en;
  logic [5*NL-1:0]  x_cls, y_cls, z_cls;
  logic [4*NL-1:0]  res_cls;
  logic             commit, flush;
  logic             csr_we, csr_set, csr_clr;
  logic [4:0]       csr_wdata;
  logic [4:0]       fflags;
  logic [$clog2(DEPTH):0] pending_cnt;
  logic             commit_err;

  always #5 clk = ~clk;

  fpu_fflags_accumulator #(.NUM_LANES(NL), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .op_type     (op_type),
    .lane_en     (lane_en),
    .x_cls       (x_cls),
    .y_cls       (y_cls),
    .z_cls       (z_cls),
    .res_cls     (res_cls),
    .commit      (commit),
    .flush       (flush),
    .csr_we      (csr_we),
    .csr_set     (csr_set),
    .csr_clr     (csr_clr),
    .csr_wdata   (csr_wdata),
    .fflags      (fflags),
    .pending_cnt (pending_cnt),
    .commit_err  (commit_err)
  );

  int checks = 0;
  int errors = 0;

  logic [4:0] m_fflags;
  logic       m_err;
  logic [4:0] m_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flags of one lane, written straight from the IEEE exception rules.
  function automatic logic [4:0] ref_lane(input logic [2:0] op, input logic [4:0] x,
                                          input logic [4:0] y, input logic [4:0] z,
                                          input logic [3:0] r);
    bit sx, sy, sz, xn, yn, xi, yi, zi, xz, yz, nv, dz, pinf;
    sx = x[4]; sy = y[4]; sz = z[4];
    xn = x[2]; yn = y[2];
    xi = x[1]; yi = y[1]; zi = z[1];
    xz = x[0]; yz = y[0];
    nv = x[3] || y[3] || z[3] || r[3];
    pinf = (xi || yi) && !xz && !yz && !xn && !yn;
    case (op)
      3'd0: if (xi && yi && sx != sy) nv = 1;
      3'd1: if (xi && yi && sx == sy) nv = 1;
      3'd2: if ((xz && yi) || (xi && yz)) nv = 1;
      3'd3: if ((xz && yi) || (xi && yz) || (pinf && zi && (sx ^ sy) != sz)) nv = 1;
      3'd4: if ((xz && yi) || (xi && yz) || (pinf && zi && (sx ^ sy) == sz)) nv = 1;
      3'd5: if ((xz && yz) || (xi && yi)) nv = 1;
      3'd6: if (sx && !xz && !xn) nv = 1;
      default: ;
    endcase
    dz = (op == 3'd5) && yz && !xn && !xi && !xz;
    if (nv || dz) return {nv, dz, 3'b000};
    return {2'b00, r[2], r[1], r[2] | r[1] | r[0]};
  endfunction

  function automatic logic [4:0] ref_entry();
    logic [4:0] e = 5'b0;
    for (int i = 0; i < NL; i++)
      if (lane_en[i])
        e |= ref_lane(op_type, x_cls[5*i +: 5], y_cls[5*i +: 5], z_cls[5*i +: 5], res_cls[4*i +: 4]);
    return e;
  endfunction

  // Advance the model with the inputs presented this cycle, clock, then compare.
  task automatic tick();
    int         cnt;
    bit         enq_ok, pop;
    logic [4:0] ent, committed, base;
    cnt = m_q.size();
    if (!rst_n) begin
      m_q.delete();
      m_fflags = 5'b0;
      m_err    = 1'b0;
    end else begin
      enq_ok    = enq_valid && cnt < DEPTH;
      pop       = commit && cnt > 0;
      ent       = ref_entry();
      committed = pop ? m_q[0] : 5'b0;
      if (csr_we)       base = csr_wdata;
      else if (csr_set) base = m_fflags | csr_wdata;
      else if (csr_clr) base = m_fflags & ~csr_wdata;
      else              base = m_fflags;
      m_fflags = base | committed;
      if (commit && cnt == 0) m_err = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (flush) m_q.delete();
      else if (enq_ok) m_q.push_back(ent);
    end
    @(posedge clk);
    #1;
    check("fflags", fflags, m_fflags);
    check("pending_cnt", pending_cnt, m_q.size());
    check("enq_ready", enq_ready, m_q.size() < DEPTH);
    check("commit_err", commit_err, m_err);
  endtask

  task automatic idle();
    enq_valid = 0; commit = 0; flush = 0;
    csr_we = 0; csr_set = 0; csr_clr = 0; csr_wdata = '0;
  endtask

  task automatic set_lane(input int i, input logic [4:0] x, input logic [4:0] y,
                          input logic [4:0] z, input logic [3:0] r);
    x_cls[5*i +: 5] = x;
    y_cls[5*i +: 5] = y;
    z_cls[5*i +: 5] = z;
    res_cls[4*i +: 4] = r;
  endtask

  // Enqueue one op, commit it, compare fflags, then clear fflags via CSR write.
  task automatic do_op(input string tag, input logic [4:0] exp);
    enq_valid = 1; tick(); enq_valid = 0;
    commit = 1; tick(); commit = 0;
    check(tag, fflags, exp);
    csr_we = 1; csr_wdata = 5'b0; tick(); csr_we = 0;
  endtask

  function automatic logic [4:0] rand_cls();
    logic [4:0] c;
    for (int b = 0; b < 5; b++) c[b] = ($urandom_range(0, 3) == 0);
    return c;
  endfunction

  initial begin
    idle();
    rst_n = 0; op_type = 3'd0; lane_en = '0;
    x_cls = '0; y_cls = '0; z_cls = '0; res_cls = '0;
    tick(); tick();
    check("rst_fflags", fflags, 5'b0);
    check("rst_cnt", pending_cnt, 0);
    check("rst_ready", enq_ready, 1);
    check("rst_err", commit_err, 0);
    rst_n = 1;

    // Inf - Inf through ADD and SUB; idle lane carries an SNaN that must be masked
    op_type = 3'd0; lane_en = 2'b01;
    set_lane(0, C_PINF, C_NINF, C_FIN, 4'b0000);
    set_lane(1, C_SNAN, C_FIN, C_FIN, 4'b0001);
    do_op("add_inf_inf", 5'b10000);
    op_type = 3'd1;
    set_lane(0, C_PINF, C_PINF, C_FIN, 4'b0000);
    do_op("sub_inf_inf", 5'b10000);

    op_type = 3'd5; lane_en = 2'b11;
    set_lane(0, C_FIN, C_PZERO, C_FIN, 4'b0000);
    set_lane(1, C_FIN, C_FIN, C_FIN, 4'b0001);
    do_op("div_dz_nx", 5'b01001);
    lane_en = 2'b01;
    set_lane(0, C_PZERO, C_PZERO, C_FIN, 4'b0001);
    do_op("div_0_0", 5'b10000);

    op_type = 3'd3;
    set_lane(0, C_PINF, C_FIN, C_NINF, 4'b0000);
    do_op("fma_inf_minf", 5'b10000);
    op_type = 3'd4;
    set_lane(0, C_PINF, C_FIN, C_PINF, 4'b0000);
    do_op("fms_inf_pinf", 5'b10000);
    op_type = 3'd3;
    do_op("fma_inf_pinf", 5'b00000);

    // Fill with NX, OF, UF, DZ entries
    op_type = 3'd0; enq_valid = 1;
    set_lane(0, C_FIN, C_FIN, C_FIN, 4'b0001); tick();
    set_lane(0, C_FIN, C_FIN, C_FIN, 4'b0100); tick();
    set_lane(0, C_FIN, C_FIN, C_FIN, 4'b0010); tick();
    op_type = 3'd5;
    set_lane(0, C_FIN, C_PZERO, C_FIN, 4'b0000); tick();
    check("full_ready", enq_ready, 0);
    check("full_cnt", pending_cnt, 4);
    commit = 1; tick();
    check("full_commit_cnt", pending_cnt, 3);
    enq_valid = 0; flush = 1; tick(); idle();
    check("flush_fflags", fflags, 5'b00101);
    check("flush_cnt", pending_cnt, 0);

    // CSR write racing a commit; then clear and set priority
    csr_we = 1; csr_wdata = 5'b00001; tick(); idle();
    op_type = 3'd0; set_lane(0, C_FIN, C_FIN, C_FIN, 4'b0100);
    enq_valid = 1; tick(); idle();
    csr_we = 1; csr_wdata = 5'b0; commit = 1; tick(); idle();
    check("csr_we_commit", fflags, 5'b00101);
    csr_clr = 1; csr_wdata = 5'b00100; tick(); idle();
    check("csr_clr", fflags, 5'b00001);
    csr_set = 1; csr_wdata = 5'b10000; tick(); idle();
    check("csr_set", fflags, 5'b10001);
    csr_we = 1; csr_set = 1; csr_wdata = 5'b00010; tick(); idle();
    check("csr_we_prio", fflags, 5'b00010);

    commit = 1; tick(); idle();
    check("empty_commit_err", commit_err, 1);
    check("empty_commit_fflags", fflags, 5'b00010);

    enq_valid = 1; flush = 1; tick(); idle();
    check("flush_enq_cnt", pending_cnt, 0);

    enq_valid = 1; tick(); tick(); tick(); idle();
    check("pre_rst_cnt", pending_cnt, 3);
    rst_n = 0; tick(); rst_n = 1;
    check("mid_rst_cnt", pending_cnt, 0);
    check("mid_rst_fflags", fflags, 5'b0);
    check("mid_rst_err", commit_err, 0);

    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      op_type   = 3'($urandom_range(0, 7));
      lane_en   = NL'($urandom);
      for (int i = 0; i < NL; i++)
        set_lane(i, rand_cls(), rand_cls(), rand_cls(), 4'($urandom));
      enq_valid = ($urandom_range(0, 9) < 6);
      commit    = ($urandom_range(0, 9) < 4);
      flush     = ($urandom_range(0, 19) == 0);
      csr_we    = ($urandom_range(0, 9) == 0);
      csr_set   = ($urandom_range(0, 9) == 0);
      csr_clr   = ($urandom_range(0, 9) == 0);
      csr_wdata = 5'($urandom);
      tick();
    end
    idle(); rst_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
